// File: rtl/fb_scanout_reader.sv
// Frame-buffer scanout reader.
// Avalon-MM read master that walks one frame of 32-bit words in the on-chip
// frame-buffer RAM and replays them as an Avalon-ST pixel stream. Reads are
// only issued when the prefetch FIFO is guaranteed to have room for them once
// the fixed RAM read latency has elapsed, so sink backpressure can never
// overflow the FIFO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; nothing issued, nothing buffered
//   S_FETCH | issuing reads while FIFO + in-flight credit allows
//   S_DRAIN | all reads issued; waiting for the sink to take the last word

module fb_scanout_reader #(
   parameter int BASE_ADDR    = 0,
   parameter int NUM_WORDS    = 76800,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        continuous,
   output logic        busy,
   output logic        frame_done,
   output logic [16:0] avm_address,
   output logic        avm_chipselect,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic        avm_clken,
   input  logic [31:0] avm_readdata,
   output logic [31:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_sop,
   output logic        pix_eop
);

   localparam int          AW    = $clog2(FIFO_DEPTH);
   // One spare bit above the depth so count + inflight never wraps.
   localparam int          CW    = AW + 2;
   localparam logic [16:0] BASE  = 17'(BASE_ADDR);
   localparam logic [16:0] LAST  = 17'(NUM_WORDS - 1);
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [16:0]             r_issue_cnt;
   logic [16:0]             r_pop_cnt;
   logic [16:0]             r_addr;
   logic                    r_cs;
   logic                    r_done;
   logic [READ_LATENCY-1:0] r_vld;
   logic [CW-1:0]           r_inflight;
   logic [CW-1:0]           r_count;
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [31:0]             r_mem [FIFO_DEPTH];

   logic                    w_issue;
   logic                    w_clr;
   logic                    w_done;
   logic                    w_wr;
   logic                    w_pop;
   logic                    w_credit;
   logic [CW-1:0]           w_used;
   logic [CW-1:0]           w_limit;

   // FIFO status, handshake and the read-issue credit check.
   always_comb begin
      pix_valid = (r_count != '0);
      w_pop     = pix_valid & pix_ready;
      w_wr      = r_vld[READ_LATENCY-1];
      w_used    = r_count + r_inflight;
      // A pop in this cycle frees a slot in time for the new read to land,
      // which is what lets the pipeline sustain one word per cycle.
      w_limit   = DEPTH + {{(CW-1){1'b0}}, w_pop};
      w_credit  = (w_used < w_limit);
   end

   // Next-state and frame control decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_clr       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_FETCH;
               w_clr       = 1'b1;
            end
         end
         S_FETCH: begin
            if (w_credit) begin
               w_issue = 1'b1;
               if (r_issue_cnt == LAST) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_pop && (r_pop_cnt == LAST)) begin
               w_done      = 1'b1;
               w_clr       = 1'b1;
               w_state_nxt = continuous ? S_FETCH : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame position counters for issued reads and accepted pixels.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_issue_cnt <= '0;
         r_pop_cnt   <= '0;
      end else begin
         if (w_clr) begin
            r_issue_cnt <= '0;
         end else if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 17'd1;
         end
         if (w_clr) begin
            r_pop_cnt <= '0;
         end else if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + 17'd1;
         end
      end
   end

   // Registered read strobe and address; address wraps in the 17-bit space.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cs   <= 1'b0;
         r_addr <= BASE;
         r_done <= 1'b0;
      end else begin
         r_cs   <= w_issue;
         r_done <= w_done;
         if (w_issue) begin
            r_addr <= BASE + r_issue_cnt;
         end
      end
   end

   // Valid shift register tracking each strobe until its data reaches the RAM port.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= r_cs;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   // Reads committed but not yet written into the FIFO.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_inflight <= '0;
      end else begin
         case ({w_issue, w_wr})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // FIFO pointers and occupancy; a write and a pop together leave the count unchanged.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are meaningless whenever the count says empty.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= avm_readdata;
      end
   end

   // Output drive; pixel fields are forced to zero while nothing is valid.
   always_comb begin
      busy           = (r_state != S_IDLE);
      frame_done     = r_done;
      avm_address    = r_addr;
      avm_chipselect = r_cs;
      avm_write      = 1'b0;
      avm_byteenable = 4'hF;
      avm_clken      = 1'b1;
      pix_data       = pix_valid ? r_mem[r_rd_ptr] : 32'h0;
      pix_sop        = pix_valid & (r_pop_cnt == 17'd0);
      pix_eop        = pix_valid & (r_pop_cnt == LAST);
   end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader: three instances with different
// frame sizes, base addresses and read latencies, each behind a RAM model
// whose word at address a is a + 0x100.

module tb_fb_scanout_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instance A: 8 words, base 0, latency 1 ----------------
   logic        a_rst, a_start, a_cont, a_busy, a_done, a_cs, a_wr, a_clken;
   logic        a_valid, a_ready, a_sop, a_eop;
   logic [16:0] a_addr;
   logic [3:0]  a_be;
   logic [31:0] a_rd, a_data;

   fb_scanout_reader #(.BASE_ADDR(0), .NUM_WORDS(8), .READ_LATENCY(1), .FIFO_DEPTH(16)) u_a (
      .clk(clk), .reset_n(a_rst), .start(a_start), .continuous(a_cont),
      .busy(a_busy), .frame_done(a_done), .avm_address(a_addr),
      .avm_chipselect(a_cs), .avm_write(a_wr), .avm_byteenable(a_be),
      .avm_clken(a_clken), .avm_readdata(a_rd), .pix_data(a_data),
      .pix_valid(a_valid), .pix_ready(a_ready), .pix_sop(a_sop), .pix_eop(a_eop));

   always @(posedge clk) a_rd <= a_cs ? ({15'd0, a_addr} + 32'h100) : 32'hDEADBEEF;

   logic [33:0] a_q[$];
   int          a_t[$];
   int          a_cs_n = 0, a_done_n = 0, a_done_t = 0;
   always @(negedge clk) begin
      if (a_valid && a_ready) begin
         a_q.push_back({a_sop, a_eop, a_data});
         a_t.push_back(cyc);
      end
      if (a_cs) a_cs_n++;
      if (a_done) begin
         a_done_n++;
         a_done_t = cyc;
      end
   end

   // ---------------- instance B: 4 words, base 0x1FFFE, latency 2 ----------------
   logic        b_rst, b_start, b_cont, b_busy, b_done, b_cs, b_wr, b_clken;
   logic        b_valid, b_ready, b_sop, b_eop;
   logic [16:0] b_addr;
   logic [3:0]  b_be;
   logic [31:0] b_rd, b_p0, b_data;

   fb_scanout_reader #(.BASE_ADDR(32'h1FFFE), .NUM_WORDS(4), .READ_LATENCY(2), .FIFO_DEPTH(16)) u_b (
      .clk(clk), .reset_n(b_rst), .start(b_start), .continuous(b_cont),
      .busy(b_busy), .frame_done(b_done), .avm_address(b_addr),
      .avm_chipselect(b_cs), .avm_write(b_wr), .avm_byteenable(b_be),
      .avm_clken(b_clken), .avm_readdata(b_rd), .pix_data(b_data),
      .pix_valid(b_valid), .pix_ready(b_ready), .pix_sop(b_sop), .pix_eop(b_eop));

   always @(posedge clk) begin
      b_p0 <= b_cs ? ({15'd0, b_addr} + 32'h100) : 32'hDEADBEEF;
      b_rd <= b_p0;
   end

   logic [33:0] b_q[$];
   int          b_t[$];
   logic [16:0] b_aq[$];
   int          b_done_n = 0;
   always @(negedge clk) begin
      if (b_valid && b_ready) begin
         b_q.push_back({b_sop, b_eop, b_data});
         b_t.push_back(cyc);
      end
      if (b_cs) b_aq.push_back(b_addr);
      if (b_done) b_done_n++;
   end

   // ---------------- instance C: 40 words, base 0, latency 2 ----------------
   logic        c_rst, c_start, c_cont, c_busy, c_done, c_cs, c_wr, c_clken;
   logic        c_valid, c_ready, c_sop, c_eop;
   logic [16:0] c_addr;
   logic [3:0]  c_be;
   logic [31:0] c_rd, c_p0, c_data;

   fb_scanout_reader #(.BASE_ADDR(0), .NUM_WORDS(40), .READ_LATENCY(2), .FIFO_DEPTH(16)) u_c (
      .clk(clk), .reset_n(c_rst), .start(c_start), .continuous(c_cont),
      .busy(c_busy), .frame_done(c_done), .avm_address(c_addr),
      .avm_chipselect(c_cs), .avm_write(c_wr), .avm_byteenable(c_be),
      .avm_clken(c_clken), .avm_readdata(c_rd), .pix_data(c_data),
      .pix_valid(c_valid), .pix_ready(c_ready), .pix_sop(c_sop), .pix_eop(c_eop));

   always @(posedge clk) begin
      c_p0 <= c_cs ? ({15'd0, c_addr} + 32'h100) : 32'hDEADBEEF;
      c_rd <= c_p0;
   end

   logic [33:0] c_q[$];
   int          c_cs_n = 0, c_done_n = 0, c_stab_err = 0;
   logic        c_hold = 1'b0;
   logic [33:0] c_held = '0;
   always @(negedge clk) begin
      if (c_valid && c_ready) c_q.push_back({c_sop, c_eop, c_data});
      if (c_cs) c_cs_n++;
      if (c_done) c_done_n++;
      if (c_hold && !(c_valid && ({c_sop, c_eop, c_data} == c_held))) c_stab_err++;
      c_hold = c_valid && !c_ready;
      c_held = {c_sop, c_eop, c_data};
   end

   // Expected {sop, eop, data} for beat i of an n-word frame at base 0.
   function automatic logic [33:0] beat0(input int i, input int n);
      logic [31:0] d;
      d = 32'h100 + 32'(i);
      return {(i == 0), (i == n - 1), d};
   endfunction

   logic [31:0] b_exp_data [4] = '{32'h200FE, 32'h200FF, 32'h00100, 32'h00101};
   logic [16:0] b_exp_addr [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};

   initial begin
      int q0, t_start, cs0, d0;
      logic [33:0] e;

      a_rst = 0; a_start = 0; a_cont = 0; a_ready = 1;
      b_rst = 0; b_start = 0; b_cont = 0; b_ready = 1;
      c_rst = 0; c_start = 0; c_cont = 0; c_ready = 1;
      step(); step();

      // Reset state.
      check("rst_busy",  a_busy,  0);
      check("rst_done",  a_done,  0);
      check("rst_cs",    a_cs,    0);
      check("rst_addr",  a_addr,  0);
      check("rst_addrb", b_addr,  17'h1FFFE);
      check("rst_valid", a_valid, 0);
      check("rst_sop",   a_sop,   0);
      check("rst_eop",   a_eop,   0);
      check("rst_data",  a_data,  0);
      check("const_wr",  a_wr,    0);
      check("const_be",  a_be,    4'hF);
      check("const_ck",  a_clken, 1);

      a_rst = 1; b_rst = 1; c_rst = 1;
      step();

      // A: single frame with an always-ready sink.
      q0 = a_q.size();
      a_start = 1; t_start = cyc + 1; step(); a_start = 0;
      check("a_busy_run", a_busy, 1);
      for (int k = 0; k < 100 && a_done_n < 1; k++) step();
      check("a_done_n", a_done_n, 1);
      check("a_nbeats", a_q.size() - q0, 8);
      if (a_q.size() >= q0 + 8) begin
         for (int i = 0; i < 8; i++) check("a_beat", a_q[q0+i], beat0(i, 8));
         check("a_first_t", a_t[q0],   t_start + 3);
         check("a_last_t",  a_t[q0+7], t_start + 10);
      end
      check("a_done_t", a_done_t, t_start + 11);
      step();
      check("a_busy_end", a_busy, 0);
      check("a_done_pulse", a_done, 0);

      // C: sink stalled, reads must stop at the FIFO depth.
      cs0 = c_cs_n; q0 = c_q.size(); d0 = c_done_n;
      c_ready = 0;
      c_start = 1; step(); c_start = 0;
      for (int k = 0; k < 40; k++) step();
      check("c_cs_stall", c_cs_n - cs0, 16);
      check("c_hold_v",   c_valid, 1);
      check("c_hold_d",   {c_sop, c_eop, c_data}, beat0(0, 40));
      c_ready = 1;
      for (int k = 0; k < 300 && c_done_n < d0 + 1; k++) step();
      check("c_done_n", c_done_n - d0, 1);
      check("c_nbeats", c_q.size() - q0, 40);
      if (c_q.size() >= q0 + 40)
         for (int i = 0; i < 40; i++) check("c_beat", c_q[q0+i], beat0(i, 40));
      check("c_cs_total", c_cs_n - cs0, 40);

      // C: random sink readiness.
      step();
      q0 = c_q.size(); d0 = c_done_n;
      c_start = 1; step(); c_start = 0;
      for (int k = 0; k < 2000 && c_done_n < d0 + 1; k++) begin
         c_ready = 1'($urandom_range(0, 1));
         step();
      end
      c_ready = 1;
      step();
      check("cr_done_n", c_done_n - d0, 1);
      check("cr_nbeats", c_q.size() - q0, 40);
      if (c_q.size() >= q0 + 40)
         for (int i = 0; i < 40; i++) check("cr_beat", c_q[q0+i], beat0(i, 40));
      check("cr_stable", c_stab_err, 0);
      check("cr_busy", c_busy, 0);

      // B: continuous frames, wrapping addresses, continuous dropped in frame 2.
      b_cont = 1;
      b_start = 1; t_start = cyc + 1; step(); b_start = 0;
      for (int k = 0; k < 200 && b_done_n < 1; k++) step();
      check("b_done1", b_done_n, 1);
      check("b_busy_gap", b_busy, 1);
      b_cont = 0;
      for (int k = 0; k < 200 && b_done_n < 2; k++) step();
      for (int k = 0; k < 10; k++) step();
      check("b_done2", b_done_n, 2);
      check("b_busy_end", b_busy, 0);
      check("b_nbeats", b_q.size(), 8);
      check("b_naddr", b_aq.size(), 8);
      if (b_q.size() >= 8) begin
         check("b_first_t", b_t[0], t_start + 4);
         for (int i = 0; i < 8; i++) begin
            e = {((i % 4) == 0), ((i % 4) == 3), b_exp_data[i % 4]};
            check("b_beat", b_q[i], e);
         end
      end
      if (b_aq.size() >= 8)
         for (int i = 0; i < 8; i++) check("b_addr", b_aq[i], b_exp_addr[i % 4]);

      // A: reset pulse mid-frame with data buffered, then a clean restart.
      a_ready = 0;
      a_start = 1; step(); a_start = 0;
      for (int k = 0; k < 6; k++) step();
      check("a_mid_valid", a_valid, 1);
      a_rst = 0; step();
      check("mr_busy",  a_busy,  0);
      check("mr_cs",    a_cs,    0);
      check("mr_addr",  a_addr,  0);
      check("mr_valid", a_valid, 0);
      check("mr_sop",   a_sop,   0);
      check("mr_data",  a_data,  0);
      a_rst = 1; step();
      check("mr_cs_after", a_cs, 0);
      check("mr_valid_after", a_valid, 0);
      q0 = a_q.size(); d0 = a_done_n;
      a_ready = 1;
      a_start = 1; step(); a_start = 0;
      for (int k = 0; k < 100 && a_done_n < d0 + 1; k++) step();
      check("mr_done_n", a_done_n - d0, 1);
      check("mr_nbeats", a_q.size() - q0, 8);
      if (a_q.size() >= q0 + 8)
         for (int i = 0; i < 8; i++) check("mr_beat", a_q[q0+i], beat0(i, 8));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
